// File: rtl/acc_multicycle_cpu_if.sv
// ---------------------------------------------------------------------------
// acc_multicycle_cpu_if
// Program/data load bus of the accumulator CPU. The loader (testbench or boot
// logic) drives it through the master modport; the core samples it through
// the slave modport. Writes are only honoured by the core while rst is high.
//   load_en    memory write strobe
//   load_sel   0 = instruction memory, 1 = data memory
//   load_addr  write address (ADDR_W bits)
//   load_data  write data (4+ADDR_W bits, one instruction word)
// ---------------------------------------------------------------------------
interface acc_multicycle_cpu_if #(
    parameter int ADDR_W = 5
);
    logic              load_en;
    logic              load_sel;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W+3:0] load_data;

    modport master (
        output load_en,
        output load_sel,
        output load_addr,
        output load_data
    );

    modport slave (
        input load_en,
        input load_sel,
        input load_addr,
        input load_data
    );
endinterface

// File: rtl/acc_multicycle_cpu.sv
// ---------------------------------------------------------------------------
// acc_multicycle_cpu
// Multi-cycle accumulator processor: FETCH / DECODE / EXEC per instruction,
// plus a terminal HALT state left only through rst. Instruction and data
// memories are internal, synchronous-write / synchronous-read, and are filled
// through the load bus while rst is held high.
//
// Parameters: DATA_W (accumulator/data width), ADDR_W (address width),
//             CNT_W (retired-instruction counter width).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         load bus (slave modport of acc_multicycle_cpu_if)
//   pc           program counter
//   acc          accumulator
//   zf, cf       zero / carry flags
//   out_data     last value written by OUT; out_valid pulses with each update
//   halted       core is in HALT
//   instr_count  retired instructions, saturating
//
// Optional feature: define ACC_CPU_CALL_EN to turn opcode C into CALL and
// opcode D into RET with a single-level link register. Without it both are NOPs.
// ---------------------------------------------------------------------------
module acc_multicycle_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    acc_multicycle_cpu_if.slave        load,
    output logic [ADDR_W-1:0]          pc,
    output logic [DATA_W-1:0]          acc,
    output logic                       zf,
    output logic                       cf,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic                       halted,
    output logic [CNT_W-1:0]           instr_count
);
    localparam int IW    = 4 + ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;
    // Bits copied when a word is narrowed/widened into DATA_W.
    localparam int LW    = (DATA_W < IW) ? DATA_W : IW;
    localparam int OW    = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;
`ifdef ACC_CPU_CALL_EN
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
`endif
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
    state_t state, state_nx;

    logic [IW-1:0]     imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] mdr;
    logic [3:0]        opc;
    logic [ADDR_W-1:0] opnd;
`ifdef ACC_CPU_CALL_EN
    logic [ADDR_W-1:0] link;
`endif

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] exec_acc;
    logic              exec_zf;
    logic              exec_cf;
    logic [ADDR_W-1:0] exec_pc;
    logic              exec_out;

    assign opc  = ir[IW-1:ADDR_W];
    assign opnd = ir[ADDR_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] fit_load(input logic [IW-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        r[LW-1:0] = d[LW-1:0];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] fit_imm(input logic [ADDR_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        r[OW-1:0] = d[OW-1:0];
        return r;
    endfunction

    // Extra top bit carries the carry-out of ADD and the borrow of SUB.
    assign sum  = {1'b0, acc} + {1'b0, mdr};
    assign diff = {1'b0, acc} - {1'b0, mdr};

    always_comb begin
        exec_acc = acc;
        exec_zf  = zf;
        exec_cf  = cf;
        exec_pc  = pc;
        exec_out = 1'b0;
        case (opc)
            OP_LDA: begin
                exec_acc = mdr;
                exec_zf  = (mdr == '0);
            end
            OP_ADD: begin
                exec_acc = sum[DATA_W-1:0];
                exec_cf  = sum[DATA_W];
                exec_zf  = (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
                exec_acc = diff[DATA_W-1:0];
                exec_cf  = diff[DATA_W];
                exec_zf  = (diff[DATA_W-1:0] == '0);
            end
            OP_AND: begin
                exec_acc = acc & mdr;
                exec_cf  = 1'b0;
                exec_zf  = ((acc & mdr) == '0);
            end
            OP_OR: begin
                exec_acc = acc | mdr;
                exec_cf  = 1'b0;
                exec_zf  = ((acc | mdr) == '0);
            end
            OP_LDI: begin
                exec_acc = fit_imm(opnd);
                exec_zf  = (fit_imm(opnd) == '0);
            end
            OP_JMP: exec_pc = opnd;
            // Flags are registers, so these see the values from before EXEC.
            OP_JZ:  if (zf) exec_pc = opnd;
            OP_JC:  if (cf) exec_pc = opnd;
            OP_OUT: exec_out = 1'b1;
`ifdef ACC_CPU_CALL_EN
            OP_CALL: exec_pc = opnd;
            OP_RET:  exec_pc = link;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  state_nx = DECODE;
            DECODE: state_nx = EXEC;
            EXEC:   state_nx = (opc == OP_HLT) ? HALT : FETCH;
            HALT:   state_nx = HALT;
        endcase
    end

    // Memories: loads only under reset; STA only from a completed EXEC, so a
    // reset landing mid-instruction never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (load.load_en) begin
                if (load.load_sel) dmem[load.load_addr] <= fit_load(load.load_data);
                else               imem[load.load_addr] <= load.load_data;
            end
        end else if (state == EXEC && opc == OP_STA) begin
            dmem[opnd] <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            acc         <= '0;
            zf          <= 1'b0;
            cf          <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            ir          <= '0;
            mdr         <= '0;
`ifdef ACC_CPU_CALL_EN
            link        <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                // FETCH -> DECODE
                FETCH: begin
                    ir <= imem[pc];
                    pc <= pc + ADDR_W'(1);
                end
                // DECODE -> EXEC
                DECODE: mdr <= dmem[opnd];
                // EXEC -> FETCH / HALT
                EXEC: begin
                    acc         <= exec_acc;
                    zf          <= exec_zf;
                    cf          <= exec_cf;
                    pc          <= exec_pc;
                    instr_count <= sat_inc(instr_count);
                    if (exec_out) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                    if (opc == OP_HLT) halted <= 1'b1;
`ifdef ACC_CPU_CALL_EN
                    // pc already points past the CALL: that is the return address.
                    if (opc == OP_CALL) link <= pc;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
